// File: rtl/memory_requester.sv
// Drives the level-sensitive memory port for host WRITE/READ/FILL/CHECKSUM commands; WRITE resp 3 cycles, READ SETTLE+1.
// cmd_ready only in IDLE (host holds cmd_valid until accepted); responses are single-cycle pulses with no backpressure.
module memory_requester #(
  parameter int ADDR_LIMIT = 8,
  parameter int SETTLE     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       mem_set,
  output logic [7:0] mem_address,
  output logic [7:0] mem_value,
  input  logic [7:0] mem_out
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_RESP} state_t;

  localparam logic [8:0] LIMIT     = 9'(ADDR_LIMIT);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] beats_q, beats_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] sum_q, sum_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       mem_set_q, mem_set_d;
  logic [7:0] mem_address_q, mem_address_d;
  logic [7:0] mem_value_q, mem_value_d;

  logic       accept;
  logic       is_multi;
  logic       is_write;
  logic [8:0] end_addr;
  logic       range_err;
  logic [7:0] beats_in;
  logic [7:0] rd_sum;

  // WRITE/FILL have op[0]=0; FILL/CHECKSUM have op[1]=1.
  assign accept    = cmd_valid && cmd_ready_q;
  assign is_multi  = cmd_op[1];
  assign is_write  = ~cmd_op[0];
  assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign range_err = is_multi ? (end_addr > LIMIT) : ({1'b0, cmd_addr} >= LIMIT);
  assign beats_in  = is_multi ? cmd_len : 8'd1;
  assign rd_sum    = sum_q + mem_out;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    beats_d       = beats_q;
    settle_d      = settle_q;
    sum_d         = sum_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = 1'b0;
    mem_address_d = mem_address_q;
    mem_value_d   = mem_value_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = cmd_addr;
          data_d = cmd_data;
          sum_d  = 8'd0;
          if (range_err) begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = 8'd0;
          end else if (beats_in == 8'd0) begin
            state_d    = S_RESP;
            rsp_data_d = is_write ? cmd_data : 8'd0;
          end else if (is_write) begin
            state_d       = S_WR;
            mem_address_d = cmd_addr;
            mem_value_d   = cmd_data;
            beats_d       = beats_in - 8'd1;
          end else begin
            state_d       = S_RD;
            mem_address_d = cmd_addr;
            settle_d      = SETTLE_M1;
            beats_d       = beats_in - 8'd1;
          end
        end
      end
      S_WR: state_d = S_GAP;
      S_GAP: begin
        if (beats_q != 8'd0) begin
          state_d       = S_WR;
          addr_d        = addr_q + 8'd1;
          mem_address_d = addr_q + 8'd1;
          mem_value_d   = data_q;
          beats_d       = beats_q - 8'd1;
        end else begin
          state_d    = S_RESP;
          rsp_data_d = data_q;
        end
      end
      S_RD: begin
        // mem_out is only trusted once the address has been stable SETTLE cycles.
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else begin
          sum_d = rd_sum;
          if (beats_q != 8'd0) begin
            addr_d        = addr_q + 8'd1;
            mem_address_d = addr_q + 8'd1;
            settle_d      = SETTLE_M1;
            beats_d       = beats_q - 8'd1;
          end else begin
            state_d    = S_RESP;
            rsp_data_d = rd_sum;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_set_d   = (state_d == S_WR);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= 8'd0;
      data_q        <= 8'd0;
      beats_q       <= 8'd0;
      settle_q      <= 8'd0;
      sum_q         <= 8'd0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'd0;
      rsp_err_q     <= 1'b0;
      mem_set_q     <= 1'b0;
      mem_address_q <= 8'd0;
      mem_value_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      beats_q       <= beats_d;
      settle_q      <= settle_d;
      sum_q         <= sum_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      mem_set_q     <= mem_set_d;
      mem_address_q <= mem_address_d;
      mem_value_q   <= mem_value_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_set     = mem_set_q;
  assign mem_address = mem_address_q;
  assign mem_value   = mem_value_q;

endmodule

// File: tb/tb_memory_requester.sv
// Scoreboard bench: two requesters (SETTLE=1 and SETTLE=3), each on its own behavioural memory.
module tb_memory_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_addr = 8'd0, cmd_len = 8'd0, cmd_data = 8'd0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       rdy_a, rsp_vld_a, rsp_err_a, busy_a, set_a;
  logic [7:0] rsp_dat_a, addr_a, val_a, out_a;
  logic       rdy_b, rsp_vld_b, rsp_err_b, busy_b, set_b;
  logic [7:0] rsp_dat_b, addr_b, val_b, out_b;

  memory_requester #(.ADDR_LIMIT(8), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld_a), .cmd_ready(rdy_a), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_vld_a),
    .rsp_data(rsp_dat_a), .rsp_err(rsp_err_a), .busy(busy_a), .mem_set(set_a),
    .mem_address(addr_a), .mem_value(val_a), .mem_out(out_a));

  memory_requester #(.ADDR_LIMIT(8), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(vld_b), .cmd_ready(rdy_b), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_vld_b),
    .rsp_data(rsp_dat_b), .rsp_err(rsp_err_b), .busy(busy_b), .mem_set(set_b),
    .mem_address(addr_b), .mem_value(val_b), .mem_out(out_b));

  // Memory instances: write while set is high at a clock edge, read combinationally.
  logic       mem_init = 1'b0;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'd0;
        mem_b[i] <= 8'd0;
      end
    end else begin
      if (set_a) mem_a[addr_a] <= val_a;
      if (set_b) mem_b[addr_b] <= val_b;
    end
  end
  assign out_a = mem_a[addr_a];
  assign out_b = mem_b[addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [7:0] data; logic err; int acc; int lat; } rsp_t;
  typedef struct { logic [7:0] addr; logic [7:0] val; int when; } wr_t;
  rsp_t exp_a[$];
  rsp_t exp_b[$];
  wr_t  exp_wr_a[$];
  logic [7:0] ref_a [256];
  logic [7:0] ref_b [256];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Response cycle is counted with the accept edge closing cycle 0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_vld_a) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_a_unexpected: got data %0h err %0b, no response pending", rsp_dat_a, rsp_err_a);
        end else begin
          check("rsp_a_data", rsp_dat_a, exp_a[0].data);
          check("rsp_a_err", rsp_err_a, exp_a[0].err);
          check("rsp_a_cycle", cyc - exp_a[0].acc + 1, exp_a[0].lat);
          void'(exp_a.pop_front());
        end
      end
      if (set_a) begin
        if (exp_wr_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_a_unexpected: set high addr %0h value %0h, no write pending", addr_a, val_a);
        end else begin
          check("wr_a_addr", addr_a, exp_wr_a[0].addr);
          check("wr_a_value", val_a, exp_wr_a[0].val);
          check("wr_a_cycle", cyc, exp_wr_a[0].when);
          void'(exp_wr_a.pop_front());
        end
      end
      if (rsp_vld_b) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_b_unexpected: got data %0h err %0b, no response pending", rsp_dat_b, rsp_err_b);
        end else begin
          check("rsp_b_data", rsp_dat_b, exp_b[0].data);
          check("rsp_b_err", rsp_err_b, exp_b[0].err);
          check("rsp_b_cycle", cyc - exp_b[0].acc + 1, exp_b[0].lat);
          void'(exp_b.pop_front());
        end
      end
    end
  end

  // Presents one command, computes its outcome from the reference memory, and returns after acceptance.
  task automatic issue(input bit b, input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] len, input logic [7:0] data);
    rsp_t e;
    wr_t w;
    int n, settle, k;
    bit err;
    logic [7:0] s;
    settle = b ? 3 : 1;
    n = (op < 2'd2) ? 1 : int'(len);
    err = (op < 2'd2) ? (int'(addr) >= 8) : (int'(addr) + int'(len) > 8);
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    if (b) vld_b = 1'b1; else vld_a = 1'b1;
    k = 0;
    while (!(b ? rdy_b : rdy_a) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: dut %0d never raised cmd_ready, want 1", b);
      vld_a = 1'b0; vld_b = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    e.err = err;
    if (err) begin
      e.data = 8'd0;
      e.lat  = 1;
    end else if (op == 2'd0 || op == 2'd2) begin
      for (int i = 0; i < n; i++) begin
        if (b) ref_b[int'(addr) + i] = data;
        else begin
          ref_a[int'(addr) + i] = data;
          w.addr = addr + 8'(i);
          w.val  = data;
          w.when = e.acc + 2 * i;
          exp_wr_a.push_back(w);
        end
      end
      e.data = data;
      e.lat  = 2 * n + 1;
    end else begin
      s = 8'd0;
      for (int i = 0; i < n; i++) s += b ? ref_b[int'(addr) + i] : ref_a[int'(addr) + i];
      e.data = s;
      e.lat  = n * settle + 1;
    end
    if (b) exp_b.push_back(e); else exp_a.push_back(e);
    @(posedge clk);
    @(negedge clk);
    vld_a = 1'b0; vld_b = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_len = 8'($urandom); cmd_data = 8'($urandom);
    check("busy_after_accept", b ? busy_b : busy_a, 1);
    check("ready_after_accept", b ? rdy_b : rdy_a, 0);
  endtask

  task automatic wait_done(input bit b);
    int k;
    k = 0;
    while (((b ? exp_b.size() : exp_a.size()) != 0 || !(b ? rdy_b : rdy_a)) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_timeout: dut %0d still has %0d responses pending, want 0", b, b ? exp_b.size() : exp_a.size());
      if (b) exp_b.delete(); else exp_a.delete();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] saved_addr;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_a[i] = 8'd0;
      ref_b[i] = 8'd0;
    end
    #1;
    check("reset_ready", rdy_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_set", set_a, 0);
    check("reset_rsp_valid", rsp_vld_a, 0);
    check("reset_addr_value", {addr_a, val_a}, 0);
    repeat (3) @(negedge clk);
    mem_init = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_edge_a", rdy_a, 1);
    check("ready_first_edge_b", rdy_b, 1);

    // Directed single beats, fills, wrap-around checksum and range errors.
    issue(0, 2'd0, 8'd3, 8'd0, 8'hA5);
    issue(0, 2'd1, 8'd3, 8'd0, 8'h00);
    issue(0, 2'd2, 8'd2, 8'd4, 8'h3C);
    for (int a = 1; a <= 6; a++) issue(0, 2'd1, 8'(a), 8'd0, 8'h00);
    issue(0, 2'd0, 8'd0, 8'd0, 8'h80);
    issue(0, 2'd0, 8'd1, 8'd0, 8'h90);
    issue(0, 2'd0, 8'd2, 8'd0, 8'h10);
    issue(0, 2'd3, 8'd0, 8'd3, 8'h00);
    wait_done(0);
    saved_addr = addr_a;
    issue(0, 2'd1, 8'd8, 8'd0, 8'h00);
    wait_done(0);
    check("err_addr_held", addr_a, saved_addr);
    issue(0, 2'd2, 8'd6, 8'd3, 8'h55);
    issue(0, 2'd2, 8'd6, 8'd2, 8'h66);
    issue(0, 2'd2, 8'd4, 8'd0, 8'h77);
    issue(0, 2'd3, 8'd7, 8'd0, 8'h00);
    issue(0, 2'd3, 8'd0, 8'd8, 8'h00);

    for (int t = 0; t < 40; t++)
      issue(0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 5)), 8'($urandom));
    wait_done(0);

    // Longer settle time on the second requester.
    issue(1, 2'd0, 8'd3, 8'd0, 8'h5A);
    issue(1, 2'd1, 8'd3, 8'd0, 8'h00);
    issue(1, 2'd2, 8'd0, 8'd3, 8'hC3);
    issue(1, 2'd3, 8'd1, 8'd3, 8'h00);
    for (int t = 0; t < 12; t++)
      issue(1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 5)), 8'($urandom));
    wait_done(1);

    // Reset during the second write beat of a FILL.
    issue(0, 2'd2, 8'd0, 8'd4, 8'hE1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (set_a && addr_a == 8'd1) break;
    end
    check("second_beat_reached", {set_a, addr_a}, {1'b1, 8'd1});
    rst_n = 1'b0;
    #1;
    check("reset_set_async_drop", set_a, 0);
    check("reset_busy_drop", busy_a, 0);
    exp_a.delete();
    exp_wr_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midcmd_reset", rdy_a, 1);
    repeat (3) @(negedge clk);
    issue(0, 2'd1, 8'd0, 8'd0, 8'h00);
    wait_done(0);
    wait_done(1);
    check("writes_all_seen", exp_wr_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
